// File: rtl/bitwise_serial_unit_pkg.sv
// Shared op encodings, FSM state type and sizing helper for the chunked bitwise unit.
// Any ALU extension reuses these encodings.
package bitwise_serial_unit_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // A single chunk still needs a one-bit counter.
  function automatic int cnt_width(input int nchunk);
    return (nchunk <= 2) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/bitwise_serial_unit_if.sv
// Request/response bundle for bitwise_serial_unit.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
interface bitwise_serial_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, zr
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, zr
  );
endinterface

// File: rtl/bitwise_serial_unit_chunk.sv
// Purely combinational CHUNK-bit slice evaluator; time-multiplexed by the top over all chunks.
module bitwise_chunk
  import bitwise_serial_unit_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [1:0]       op,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_serial_unit.sv
// Handshaked bitwise logic unit: captures a/b/op, evaluates CHUNK bits per cycle,
// then presents the registered result and zero flag until the consumer takes it.
module bitwise_serial_unit
  import bitwise_serial_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bitwise_serial_unit_if.slave  bus,
  output state_t                dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("bitwise_serial_unit: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zr_q, zr_d;

  int               idx;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_y;

  // Chunk select driven by the counter; only meaningful in RUN.
  always_comb begin
    idx     = int'(cnt_q) * CHUNK;
    chunk_a = a_q[idx +: CHUNK];
    chunk_b = b_q[idx +: CHUNK];
  end

  bitwise_chunk #(.CHUNK(CHUNK)) u_chunk (
    .op (op_q),
    .a  (chunk_a),
    .b  (chunk_b),
    .y  (chunk_y)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zr_d     = zr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[idx +: CHUNK] = chunk_y;
        if (cnt_q == LAST_CNT) begin
          // Flag reflects the full word, including the chunk written this cycle.
          zr_d    = (result_d == '0);
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zr_q     <= zr_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE) && !reset;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out       = result_q;
  assign bus.zr        = zr_q;
  assign dbg_state     = state_q;

endmodule
